// File: rtl/arcade_input_mapper_if.sv
// Bundle between hps_io, the input mapper and the game core.
//   Toward the mapper: ps2_key[64:0] (bit 64 toggles per key event),
//     joystick_0/1[15:0] (0 right, 1 left, 2 down, 3 up, 4 fire,
//     5 start1, 6 start2, 7 coin), combine_joy, rotate[1:0], autofire_en.
//   Toward the core: p1_dir/p2_dir[3:0] {up,down,left,right}, p1_fire,
//     p2_fire, start1, start2, coin1, coin2.
// master: the hps_io side that produces inputs and consumes player signals.
// slave:  the mapper itself.
interface arcade_input_mapper_if;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        combine_joy;
  logic [1:0]  rotate;
  logic        autofire_en;

  logic [3:0]  p1_dir;
  logic [3:0]  p2_dir;
  logic        p1_fire;
  logic        p2_fire;
  logic        start1;
  logic        start2;
  logic        coin1;
  logic        coin2;

  modport master (
    output ps2_key, joystick_0, joystick_1, combine_joy, rotate, autofire_en,
    input  p1_dir, p2_dir, p1_fire, p2_fire, start1, start2, coin1, coin2
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, combine_joy, rotate, autofire_en,
    output p1_dir, p2_dir, p1_fire, p2_fire, start1, start2, coin1, coin2
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Player-input front end for arcade cores: turns PS/2 key events and MiSTer
// joystick words into per-player direction, fire, start and coin signals,
// with optional control rotation, timed coin pulses and autofire.
// Ports:
//   clk_sys  system clock
//   reset    synchronous, active-high reset
//   bus      arcade_input_mapper_if.slave (inputs from hps_io, outputs to core)
// Parameters:
//   PLAYERS        1 or 2; with 1 every p2 output is held at 0
//   COIN_PULSE     coin high time in clk_sys cycles (1..2^24-1)
//   AUTOFIRE_DIV   autofire half-period in clk_sys cycles (1..2^24-1)
//   COIN_ON_START  when nonzero a start1/start2 rising edge also fires coin1
module arcade_input_mapper #(
  parameter int unsigned PLAYERS       = 2,
  parameter int unsigned COIN_PULSE    = 1200000,
  parameter int unsigned AUTOFIRE_DIV  = 600000,
  parameter int unsigned COIN_ON_START = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  arcade_input_mapper_if.slave  bus
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned KEY_W = 15;

  localparam bit HAS_P2      = (PLAYERS > 1);
  localparam bit START_COINS = (COIN_ON_START != 0);

  localparam logic [CNT_W-1:0] AF_LAST   = CNT_W'(AUTOFIRE_DIV - 1);
  localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_PULSE);

  // Key state bit positions; p1/p2 direction nibbles follow the joystick
  // layout so they can be OR-ed directly with joystick[3:0].
  localparam int unsigned K_P1_RIGHT = 0;
  localparam int unsigned K_P1_LEFT  = 1;
  localparam int unsigned K_P1_DOWN  = 2;
  localparam int unsigned K_P1_UP    = 3;
  localparam int unsigned K_SPACE    = 4;
  localparam int unsigned K_LCTRL    = 5;
  localparam int unsigned K_START1   = 6;
  localparam int unsigned K_START2   = 7;
  localparam int unsigned K_COIN1    = 8;
  localparam int unsigned K_COIN2    = 9;
  localparam int unsigned K_P2_RIGHT = 10;
  localparam int unsigned K_P2_LEFT  = 11;
  localparam int unsigned K_P2_DOWN  = 12;
  localparam int unsigned K_P2_UP    = 13;
  localparam int unsigned K_FIRE2    = 14;

  // Scan codes
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_LCTRL   = 8'h14;
  localparam logic [7:0] SC_F1      = 8'h05;
  localparam logic [7:0] SC_F2      = 8'h06;
  localparam logic [7:0] SC_5       = 8'h2E;
  localparam logic [7:0] SC_6       = 8'h36;
  localparam logic [7:0] SC_R       = 8'h2D;
  localparam logic [7:0] SC_F       = 8'h2B;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_G       = 8'h34;
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_RELEASE = 8'hF0;

  // Registered state
  logic                        toggle_q,     toggle_d;
  logic [KEY_W-1:0]            key_q,        key_d;
  logic [1:0][3:0]             dir_q,        dir_d;
  logic [1:0]                  fire_q,       fire_d;
  logic [1:0]                  fire_prev_q,  fire_prev_d;
  logic [1:0]                  af_phase_q,   af_phase_d;
  logic [1:0][CNT_W-1:0]       af_cnt_q,     af_cnt_d;
  logic [1:0]                  start_q,      start_d;
  logic [1:0]                  coin_req_q,   coin_req_d;
  logic [1:0][CNT_W-1:0]       coin_cnt_q,   coin_cnt_d;
  logic [1:0]                  coin_q,       coin_d;

  // Combinational helpers
  logic        key_event;
  logic        key_pressed;
  logic        key_ext;
  logic [7:0]  key_code;
  logic [15:0] joy_any;
  logic [15:0] p1_joy;
  logic [15:0] p2_joy;
  logic [1:0][3:0] raw_dir;
  logic [1:0]  raw_fire;
  logic [1:0]  raw_start;
  logic [1:0]  coin_req;

  // Upper joystick bits carry buttons this mapper does not use.
  logic unused_joy_bits;
  assign unused_joy_bits = ^{bus.joystick_0[15:8], bus.joystick_1[15:8]};

  // Output bit order is {up,down,left,right}; each output takes a raw input.
  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input logic [1:0] r);
    logic [3:0] res;
    res = d;
    case (r)
      2'd1:    res = {d[1], d[0], d[2], d[3]};
      2'd2:    res = {d[2], d[3], d[0], d[1]};
      2'd3:    res = {d[0], d[1], d[3], d[2]};
      default: res = d;
    endcase
    return res;
  endfunction

  // PS/2 event decode into the key state register
  always_comb begin
    toggle_d    = bus.ps2_key[64];
    key_d       = key_q;
    key_event   = (bus.ps2_key[64] != toggle_q) && (bus.ps2_key[63:24] == '0);
    key_pressed = (bus.ps2_key[15:8] != SC_RELEASE);
    key_ext     = key_pressed ? (bus.ps2_key[15:8] == SC_EXT)
                              : (bus.ps2_key[23:16] == SC_EXT);
    key_code    = bus.ps2_key[7:0];

    if (key_event) begin
      // Arrows accept both the extended and the keypad codes.
      case (key_code)
        SC_UP:    key_d[K_P1_UP]    = key_pressed;
        SC_DOWN:  key_d[K_P1_DOWN]  = key_pressed;
        SC_LEFT:  key_d[K_P1_LEFT]  = key_pressed;
        SC_RIGHT: key_d[K_P1_RIGHT] = key_pressed;
        default: begin
          if (!key_ext) begin
            case (key_code)
              SC_SPACE: key_d[K_SPACE]    = key_pressed;
              SC_LCTRL: key_d[K_LCTRL]    = key_pressed;
              SC_F1:    key_d[K_START1]   = key_pressed;
              SC_F2:    key_d[K_START2]   = key_pressed;
              SC_5:     key_d[K_COIN1]    = key_pressed;
              SC_6:     key_d[K_COIN2]    = key_pressed;
              SC_R:     key_d[K_P2_UP]    = key_pressed;
              SC_F:     key_d[K_P2_DOWN]  = key_pressed;
              SC_D:     key_d[K_P2_LEFT]  = key_pressed;
              SC_G:     key_d[K_P2_RIGHT] = key_pressed;
              SC_A:     key_d[K_FIRE2]    = key_pressed;
              default:  ;
            endcase
          end
        end
      endcase
    end
  end

  // Raw per-player inputs, rotation, autofire and coin timing
  always_comb begin
    joy_any = bus.joystick_0 | bus.joystick_1;
    p1_joy  = (bus.combine_joy || !HAS_P2) ? joy_any : bus.joystick_0;
    p2_joy  = bus.combine_joy ? 16'h0000 : bus.joystick_1;

    raw_dir[0]  = key_q[K_P1_UP:K_P1_RIGHT] | p1_joy[3:0];
    raw_dir[1]  = HAS_P2 ? (key_q[K_P2_UP:K_P2_RIGHT] | p2_joy[3:0]) : 4'b0000;
    raw_fire[0] = key_q[K_SPACE] | key_q[K_LCTRL] | p1_joy[4];
    raw_fire[1] = HAS_P2 ? (key_q[K_FIRE2] | p2_joy[4]) : 1'b0;
    raw_start   = {key_q[K_START2] | joy_any[6], key_q[K_START1] | joy_any[5]};

    // Coin slot n follows joystick n; start may also feed slot 1.
    coin_req[0] = key_q[K_COIN1] | bus.joystick_0[7] | (START_COINS && (|raw_start));
    coin_req[1] = key_q[K_COIN2] | bus.joystick_1[7];

    start_d     = raw_start;
    fire_prev_d = raw_fire;
    coin_req_d  = coin_req;
    af_cnt_d    = af_cnt_q;
    af_phase_d  = af_phase_q;
    coin_cnt_d  = coin_cnt_q;
    dir_d       = '0;
    fire_d      = '0;
    coin_d      = '0;

    for (int p = 0; p < 2; p++) begin
      dir_d[p] = rotate_dir(raw_dir[p], bus.rotate);

      // Phase restarts high on every new press so the first shot is immediate.
      if (raw_fire[p] && !fire_prev_q[p]) begin
        af_cnt_d[p]   = CNT_W'(0);
        af_phase_d[p] = 1'b1;
      end else if (raw_fire[p]) begin
        if (af_cnt_q[p] == AF_LAST) begin
          af_cnt_d[p]   = CNT_W'(0);
          af_phase_d[p] = ~af_phase_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + CNT_W'(1);
        end
      end else begin
        af_cnt_d[p]   = CNT_W'(0);
        af_phase_d[p] = 1'b0;
      end
      fire_d[p] = raw_fire[p] & (af_phase_d[p] | ~bus.autofire_en);
    end

    // Counter loads on an idle rising edge; the output follows the counter
    // one edge later, giving exactly COIN_PULSE high cycles.
    for (int s = 0; s < 2; s++) begin
      if (coin_req[s] && !coin_req_q[s] && (coin_cnt_q[s] == '0)) begin
        coin_cnt_d[s] = COIN_LOAD;
      end else if (coin_cnt_q[s] != '0) begin
        coin_cnt_d[s] = coin_cnt_q[s] - CNT_W'(1);
      end
      coin_d[s] = (coin_cnt_q[s] != '0);
    end
  end

  // State registers; the toggle copy tracks the input through reset so no
  // stale event fires afterwards.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q    <= bus.ps2_key[64];
      key_q       <= '0;
      dir_q       <= '0;
      fire_q      <= '0;
      fire_prev_q <= '0;
      af_phase_q  <= '0;
      af_cnt_q    <= '0;
      start_q     <= '0;
      coin_req_q  <= '0;
      coin_cnt_q  <= '0;
      coin_q      <= '0;
    end else begin
      toggle_q    <= toggle_d;
      key_q       <= key_d;
      dir_q       <= dir_d;
      fire_q      <= fire_d;
      fire_prev_q <= fire_prev_d;
      af_phase_q  <= af_phase_d;
      af_cnt_q    <= af_cnt_d;
      start_q     <= start_d;
      coin_req_q  <= coin_req_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_q      <= coin_d;
    end
  end

  assign bus.p1_dir  = dir_q[0];
  assign bus.p2_dir  = dir_q[1];
  assign bus.p1_fire = fire_q[0];
  assign bus.p2_fire = fire_q[1];
  assign bus.start1  = start_q[0];
  assign bus.start2  = start_q[1];
  assign bus.coin1   = coin_q[0];
  assign bus.coin2   = coin_q[1];

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: two instances with different parameter sets
// share one stimulus stream; a per-instance behavioural model predicts every
// output each cycle.
module tb_arcade_input_mapper;

  localparam int unsigned NI = 2;

  localparam int unsigned P0_PLAYERS = 2;
  localparam int unsigned P0_PULSE   = 5;
  localparam int unsigned P0_DIV     = 3;
  localparam int unsigned P0_COS     = 0;
  localparam int unsigned P1_PLAYERS = 1;
  localparam int unsigned P1_PULSE   = 4;
  localparam int unsigned P1_DIV     = 1;
  localparam int unsigned P1_COS     = 1;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [64:0] ps2_key;
  logic [15:0] joy0, joy1;
  logic        combine_joy;
  logic [1:0]  rotate;
  logic        autofire_en;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper_if bus0 ();
  arcade_input_mapper_if bus1 ();

  assign bus0.ps2_key     = ps2_key;
  assign bus0.joystick_0  = joy0;
  assign bus0.joystick_1  = joy1;
  assign bus0.combine_joy = combine_joy;
  assign bus0.rotate      = rotate;
  assign bus0.autofire_en = autofire_en;
  assign bus1.ps2_key     = ps2_key;
  assign bus1.joystick_0  = joy0;
  assign bus1.joystick_1  = joy1;
  assign bus1.combine_joy = combine_joy;
  assign bus1.rotate      = rotate;
  assign bus1.autofire_en = autofire_en;

  arcade_input_mapper #(
    .PLAYERS(P0_PLAYERS), .COIN_PULSE(P0_PULSE),
    .AUTOFIRE_DIV(P0_DIV), .COIN_ON_START(P0_COS)
  ) u_dut0 (.clk_sys(clk_sys), .reset(reset), .bus(bus0.slave));

  arcade_input_mapper #(
    .PLAYERS(P1_PLAYERS), .COIN_PULSE(P1_PULSE),
    .AUTOFIRE_DIV(P1_DIV), .COIN_ON_START(P1_COS)
  ) u_dut1 (.clk_sys(clk_sys), .reset(reset), .bus(bus1.slave));

  // Reference model state
  bit   held       [NI][512];  // index {ext,code}; arrows always use ext=0
  bit   last_tog   [NI];
  bit   fire_prev  [NI][2];
  int   fire_age   [NI][2];    // edges since the current press began
  bit   req_prev   [NI][2];
  int   coin_start [NI][2];    // edge at which the running pulse was accepted
  logic [7:0] exp_dir   [NI];  // {p2_dir, p1_dir}
  logic [1:0] exp_fire  [NI];
  logic [1:0] exp_start [NI];
  logic [1:0] exp_coin  [NI];

  int cyc;
  int n_vec;
  int n_bad;

  logic [7:0] codes [16] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06,
                             8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h12};

  function automatic int cfg_players(int i); return (i == 0) ? P0_PLAYERS : P1_PLAYERS; endfunction
  function automatic int cfg_pulse(int i);   return (i == 0) ? P0_PULSE   : P1_PULSE;   endfunction
  function automatic int cfg_div(int i);     return (i == 0) ? P0_DIV     : P1_DIV;     endfunction
  function automatic bit cfg_cos(int i);     return (i == 0) ? (P0_COS != 0) : (P1_COS != 0); endfunction

  function automatic bit key_held(int i, logic [7:0] code);
    return held[i][int'(code)];
  endfunction

  // Directions in clockwise compass order: rotating by r quarter turns CW
  // means output direction o is driven by raw direction o - r.
  function automatic logic [3:0] rot_model(input logic [3:0] raw, input logic [1:0] rot);
    int pos [4];
    logic [3:0] res;
    pos[0] = 3; pos[1] = 0; pos[2] = 2; pos[3] = 1;  // up, right, down, left
    res = '0;
    for (int o = 0; o < 4; o++) res[pos[o]] = raw[pos[(o + 4 - int'(rot)) % 4]];
    return res;
  endfunction

  task automatic apply_key_event(int i);
    bit pressed, ext, arrow;
    logic [7:0] code;
    int slot;
    pressed = (ps2_key[15:8] != 8'hF0);
    ext     = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    code    = ps2_key[7:0];
    arrow   = (code == 8'h75) || (code == 8'h72) || (code == 8'h6B) || (code == 8'h74);
    slot    = (arrow || !ext) ? int'(code) : 256 + int'(code);
    held[i][slot] = pressed;
  endtask

  task automatic model_step(int i);
    bit single, st1, st2;
    logic [15:0] pj1, pj2;
    logic [3:0] r1, r2;
    logic [1:0] rf, rq;
    if (reset) begin
      for (int k = 0; k < 512; k++) held[i][k] = 1'b0;
      last_tog[i] = ps2_key[64];
      for (int p = 0; p < 2; p++) begin
        fire_prev[i][p] = 1'b0; fire_age[i][p] = 0;
        req_prev[i][p] = 1'b0;  coin_start[i][p] = -1000000;
      end
      exp_dir[i] = '0; exp_fire[i] = '0; exp_start[i] = '0; exp_coin[i] = '0;
      return;
    end
    single = (cfg_players(i) == 1);
    pj1 = (combine_joy || single) ? (joy0 | joy1) : joy0;
    pj2 = combine_joy ? 16'h0 : joy1;
    r1 = {key_held(i, 8'h75), key_held(i, 8'h72), key_held(i, 8'h6B), key_held(i, 8'h74)} | pj1[3:0];
    r2 = single ? 4'h0 :
         ({key_held(i, 8'h2D), key_held(i, 8'h2B), key_held(i, 8'h23), key_held(i, 8'h34)} | pj2[3:0]);
    exp_dir[i] = {rot_model(r2, rotate), rot_model(r1, rotate)};

    rf[0] = key_held(i, 8'h29) | key_held(i, 8'h14) | pj1[4];
    rf[1] = single ? 1'b0 : (key_held(i, 8'h1C) | pj2[4]);
    for (int p = 0; p < 2; p++) begin
      if (rf[p]) begin
        fire_age[i][p] = fire_prev[i][p] ? fire_age[i][p] + 1 : 0;
        exp_fire[i][p] = !autofire_en || (((fire_age[i][p] / cfg_div(i)) % 2) == 0);
      end else begin
        exp_fire[i][p] = 1'b0;
      end
      fire_prev[i][p] = rf[p];
    end

    st1 = key_held(i, 8'h05) | joy0[5] | joy1[5];
    st2 = key_held(i, 8'h06) | joy0[6] | joy1[6];
    exp_start[i] = {st2, st1};

    rq[0] = key_held(i, 8'h2E) | joy0[7] | (cfg_cos(i) && (st1 || st2));
    rq[1] = key_held(i, 8'h36) | joy1[7];
    for (int s = 0; s < 2; s++) begin
      exp_coin[i][s] = (cyc >= coin_start[i][s] + 1) && (cyc <= coin_start[i][s] + cfg_pulse(i));
      if (rq[s] && !req_prev[i][s] && (cyc > coin_start[i][s] + cfg_pulse(i)))
        coin_start[i][s] = cyc;
      req_prev[i][s] = rq[s];
    end

    if (ps2_key[64] != last_tog[i]) begin
      if (ps2_key[63:24] == '0) apply_key_event(i);
    end
    last_tog[i] = ps2_key[64];
  endtask

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    check_eq("u0.dir",   16'({bus0.p2_dir, bus0.p1_dir}),   16'(exp_dir[0]));
    check_eq("u0.fire",  16'({bus0.p2_fire, bus0.p1_fire}), 16'(exp_fire[0]));
    check_eq("u0.start", 16'({bus0.start2, bus0.start1}),   16'(exp_start[0]));
    check_eq("u0.coin",  16'({bus0.coin2, bus0.coin1}),     16'(exp_coin[0]));
    check_eq("u1.dir",   16'({bus1.p2_dir, bus1.p1_dir}),   16'(exp_dir[1]));
    check_eq("u1.fire",  16'({bus1.p2_fire, bus1.p1_fire}), 16'(exp_fire[1]));
    check_eq("u1.start", 16'({bus1.start2, bus1.start1}),   16'(exp_start[1]));
    check_eq("u1.coin",  16'({bus1.coin2, bus1.coin1}),     16'(exp_coin[1]));
  endtask

  task automatic step();
    @(posedge clk_sys);
    cyc++;
    for (int i = 0; i < int'(NI); i++) model_step(i);
    @(negedge clk_sys);
    compare_all();
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_key(input bit ext, input bit rel, input logic [7:0] code, input bit bad);
    logic [64:0] k;
    k = '0;
    k[64]  = ~ps2_key[64];
    k[7:0] = code;
    if (rel) begin
      k[15:8]  = 8'hF0;
      k[23:16] = ext ? 8'hE0 : 8'h00;
    end else begin
      k[15:8] = ext ? 8'hE0 : 8'h00;
    end
    if (bad) k[63:24] = {8'h00, 32'($urandom)} | 40'd1;
    ps2_key = k;
  endtask

  function automatic logic [15:0] rand_joy();
    logic [15:0] j;
    j = 16'($urandom);
    for (int b = 0; b < 5; b++) j[b] = ($urandom_range(0, 3) == 0);
    for (int b = 5; b < 8; b++) j[b] = ($urandom_range(0, 15) == 0);
    return j;
  endfunction

  initial begin
    logic [3:0] rot_exp [4];
    int coin_hi0, coin_hi1;
    rot_exp[0] = 4'b1000; rot_exp[1] = 4'b0001; rot_exp[2] = 4'b0100; rot_exp[3] = 4'b0010;
    cyc = 0; n_vec = 0; n_bad = 0;
    reset = 1'b1; ps2_key = '0; joy0 = '0; joy1 = '0;
    combine_joy = 1'b0; rotate = 2'd0; autofire_en = 1'b0;
    steps(3);
    check_eq("reset.outs", 16'({bus0.p1_dir, bus0.p2_dir, bus0.coin1, bus0.start1}), 16'h0);
    reset = 1'b0;
    steps(2);

    // Extended, released and keypad arrow
    send_key(1'b1, 1'b0, 8'h75, 1'b0); steps(2);
    check_eq("key.ext_up", 16'(bus0.p1_dir), 16'h8);
    send_key(1'b1, 1'b1, 8'h75, 1'b0); steps(2);
    check_eq("key.release", 16'(bus0.p1_dir), 16'h0);
    send_key(1'b0, 1'b0, 8'h75, 1'b0); steps(2);
    check_eq("key.keypad_up", 16'(bus0.p1_dir), 16'h8);
    send_key(1'b0, 1'b1, 8'h75, 1'b0); steps(2);

    // Rotation of a held joystick up
    joy0 = 16'h0008;
    for (int r = 0; r < 4; r++) begin
      rotate = 2'(r); step();
      check_eq("rotate.p1", 16'(bus0.p1_dir), 16'(rot_exp[r]));
    end
    joy0 = '0; rotate = 2'd0; step();

    // Coin: single pulse, re-trigger inside pulse, then a held request
    coin_hi0 = 0; coin_hi1 = 0;
    joy0 = 16'h0080; step(); coin_hi0 += int'(bus0.coin1); coin_hi1 += int'(bus1.coin1);
    joy0 = 16'h0000;
    for (int k = 0; k < 2; k++) begin step(); coin_hi0 += int'(bus0.coin1); coin_hi1 += int'(bus1.coin1); end
    joy0 = 16'h0080; step(); coin_hi0 += int'(bus0.coin1); coin_hi1 += int'(bus1.coin1);
    joy0 = 16'h0000;
    for (int k = 0; k < 9; k++) begin step(); coin_hi0 += int'(bus0.coin1); coin_hi1 += int'(bus1.coin1); end
    check_eq("coin.len_u0", 16'(coin_hi0), 16'(P0_PULSE));
    check_eq("coin.len_u1", 16'(coin_hi1), 16'(P1_PULSE));
    coin_hi0 = 0;
    joy0 = 16'h0080;
    for (int k = 0; k < 14; k++) begin step(); coin_hi0 += int'(bus0.coin1); end
    check_eq("coin.held_once", 16'(coin_hi0), 16'(P0_PULSE));
    joy0 = 16'h0000; steps(2);

    // Autofire on, release, then autofire off
    autofire_en = 1'b1; joy0 = 16'h0010; steps(20);
    joy0 = 16'h0000; step();
    check_eq("af.release", 16'(bus0.p1_fire), 16'h0);
    autofire_en = 1'b0; joy0 = 16'h0010; steps(5);
    check_eq("af.steady", 16'(bus0.p1_fire), 16'h1);
    joy0 = 16'h0000; step();

    // Player routing
    joy1 = 16'h0010; step();
    check_eq("route.sep", 16'({bus0.p1_fire, bus0.p2_fire}), 16'b01);
    combine_joy = 1'b1; step();
    check_eq("route.comb", 16'({bus0.p1_fire, bus0.p2_fire}), 16'b10);
    check_eq("route.single", 16'({bus1.p2_dir, bus1.p2_fire}), 16'h0);
    joy1 = 16'h0000; combine_joy = 1'b0; step();

    // Reset in the middle of a coin pulse
    joy0 = 16'h0080; step(); joy0 = 16'h0000; steps(2);
    reset = 1'b1; step();
    check_eq("rst.coin_abort", 16'(bus0.coin1), 16'h0);
    reset = 1'b0;
    coin_hi0 = 0;
    for (int k = 0; k < 8; k++) begin step(); coin_hi0 += int'(bus0.coin1); end
    check_eq("rst.no_pulse", 16'(coin_hi0), 16'h0);

    // Filtered event, then F1 with coin-on-start on instance 1
    send_key(1'b0, 1'b0, 8'h05, 1'b1); steps(3);
    check_eq("filter.start1", 16'(bus0.start1), 16'h0);
    send_key(1'b0, 1'b0, 8'h05, 1'b0); steps(2);
    check_eq("f1.start1", 16'({bus0.start1, bus1.start1}), 16'b11);
    step();
    check_eq("f1.coin", 16'({bus0.coin1, bus1.coin1}), 16'b01);
    steps(6);
    send_key(1'b0, 1'b1, 8'h05, 1'b0); steps(6);

    // Back-to-back key events
    send_key(1'b0, 1'b0, 8'h2D, 1'b0); step();
    send_key(1'b0, 1'b0, 8'h1C, 1'b0); steps(2);
    check_eq("b2b.p2", 16'({bus0.p2_dir, bus0.p2_fire}), 16'b10001);
    send_key(1'b0, 1'b1, 8'h2D, 1'b0); step();
    send_key(1'b0, 1'b1, 8'h1C, 1'b0); steps(3);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0)
        send_key($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 codes[$urandom_range(0, 15)], $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) joy0 = rand_joy();
      if ($urandom_range(0, 5) == 0) joy1 = rand_joy();
      if ($urandom_range(0, 19) == 0) rotate = 2'($urandom);
      if ($urandom_range(0, 39) == 0) combine_joy = ~combine_joy;
      if ($urandom_range(0, 19) == 0) autofire_en = ~autofire_en;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end for arcade cores: decodes `ps2_key` events and MiSTer joystick words into per-player direction, fire, start and coin signals for the game core. It sits between `hps_io` and the game module. It generalises per-core inline keyboard/joystick logic with:
- 1–2 players;
- four-way control rotation;
- timed coin pulses;
- per-player autofire.

## Interface
Parameters:
- `PLAYERS`, 2, number of players (1 or 2); with 1, all p2 outputs are constant 0.
- `COIN_PULSE`, 1200000, coin output high time in `clk_sys` cycles (100 ms at 12 MHz); legal range 1..2^24-1.
- `AUTOFIRE_DIV`, 600000, autofire half-period in cycles; legal range 1..2^24-1.
- `COIN_ON_START`, 0, when 1 a start1/start2 rising edge also triggers coin1.

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_key`  in  65  hps_io key event; bit 64 toggles per event.
- `joystick_0`, `joystick_1`  in  16 each  bit map: 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin.
- `combine_joy`  in  1  1: `joystick_0|joystick_1` drive player 1, and player 2 gets keyboard only.
- `rotate`  in  2  0 none, 1 rotate 90° CW, 2 rotate 180°, 3 rotate 90° CCW.
- `autofire_en`  in  1  enables autofire on both players.
- `p1_dir`, `p2_dir`  out  4  {up,down,left,right}.
- `p1_fire`, `p2_fire`, `start1`, `start2`, `coin1`, `coin2`  out  1 each.

## Operation
**Key events**
- Event detect: a registered copy of `ps2_key[64]` differs from the input.
- Events with `ps2_key[63:24]!=0` are ignored.
- pressed = `ps2_key[15:8]!=F0`.
- extended = pressed ? `ps2_key[15:8]==E0` : `ps2_key[23:16]==E0`.

**Key map** (pressed sets the key's state bit, release clears it)
- Arrow keys ignore the extended flag, so keypad arrows also work: up 75, down 72, left 6B, right 74.
- All other keys require extended=0:
  - fire1: space 29 / lctrl 14;
  - start1 F1 05, start2 F2 06;
  - coin1 '5' 2E, coin2 '6' 36;
  - p2 directions: up R 2D, down F 2B, left D 23, right G 34;
  - fire2 A 1C.

**Raw player inputs**
- Raw player n = OR of that player's key state and its joystick.
- Player 1's joystick is `joystick_0`, or `joystick_0|joystick_1` when `combine_joy=1` or `PLAYERS=1`.

**Rotation** applies to directions of both players; output ← raw:
- rotate 1: up←left, down←right, left←down, right←up.
- rotate 2: up←down, down←up, left←right, right←left.
- rotate 3: up←right, down←left, left←up, right←down.

**Autofire**, per player:
- A rising edge of raw fire clears that player's 24-bit counter and sets phase=1.
- While fire is held, the counter increments; at `AUTOFIRE_DIV-1` it wraps to 0 and phase toggles.
- Output fire = held & (phase | ~autofire_en).
- Fire released gives output 0 immediately (next edge).

**Coin**, per slot:
- Request = key OR joystick bit 7, OR (if `COIN_ON_START`) start1/start2 for slot 1.
- A request rising edge while idle loads the counter; the coin output is high for exactly `COIN_PULSE` cycles, then 0.
- Rising edges during an active pulse are ignored (no extension, no re-queue).
- A held request does not retrigger; it must drop and rise again.

**Start** outputs are level: key OR joystick.

## Timing
- All outputs are registered.
- Joystick or `rotate` change to output: 1 edge.
- PS/2 toggle to output: 2 edges (key state register, then output register).
- Coin: request rise sampled at edge k; coin is high from edge k+1 through edge k+`COIN_PULSE` and low at edge k+`COIN_PULSE`+1.
- Reset:
  - all outputs, key states, counters and phases clear to 0;
  - the toggle copy loads `ps2_key[64]`, so no spurious event after reset;
  - a coin pulse in progress is aborted (coin=0 next edge).
- Simultaneous coin1 and coin2 requests give two independent pulses.
- A `rotate` change mid-hold remaps on the next edge with no glitch state.
- Two events on consecutive cycles are both processed.

## Test plan
- Key event: send E0 75 (up) with rotate=0 → `p1_dir=1000` two edges after the toggle; send E0 F0 75 → `p1_dir=0000`; keypad 75 (non-extended) also gives 1000.
- Rotation: hold joystick_0 up (bit 3), rotate=1 → `p1_dir=0001` (right) after 1 edge; rotate=2 → 0100; rotate=3 → 0010.
- Coin timing: `COIN_PULSE=5`, pulse joystick_0 bit 7 for 1 cycle → coin1 high exactly 5 cycles. A second edge during the pulse → no extension. Holding the request → a single pulse only.
- Autofire: `AUTOFIRE_DIV=3`, autofire_en=1, hold fire 20 cycles → p1_fire alternates 3 high / 3 low starting high; release → 0 next edge; autofire_en=0 → steady high.
- Player routing: `PLAYERS=2`, combine_joy=0, joystick_1 fire → p2_fire=1, p1_fire=0; combine_joy=1 → p1_fire=1, p2_fire=0; `PLAYERS=1` → p2 outputs always 0.
- Reset/filter: assert reset mid coin pulse → coin1=0 next edge, no pulse after release. An event with `ps2_key[63:24]!=0` → no state change. `COIN_ON_START=1` with an F1 press → start1=1 and a coin1 pulse.
